router_1xn: RTL
===============

# router_1xn

Parametrised 1-to-N packet router core: the next generation of the 1x3 router. A single byte stream of header/payload/parity packets enters, and each packet is steered into one of `NUM_CH` output FIFOs by the header's address field. The block adds parameterisable width, depth and channel count, dropping of invalid-address packets, payload-length checking, a per-channel read timeout with FIFO flush, and an error-cause code.

## Interface
- `DATA_W`, default 8: data word width.
- `NUM_CH`, default 3: output channels, 2..16.
- `FIFO_DEPTH`, default 16: words per channel FIFO, power of 2, at least 4.
- `TIMEOUT`, default 30: unread cycles before a channel FIFO is flushed.
- `clock`  in  1: rising-edge clock, the only clock.
- `reset`  in  1: one clock; reset is synchronous and active-high.
- `pkt_valid`  in  1: high for header and payload words; low for the parity word.
- `data_in`  in  DATA_W: packet word.
- `read_enb`  in  NUM_CH: per-channel pop request.
- `busy`  out  1: source must hold `data_in`/`pkt_valid` while high.
- `vld_out`  out  NUM_CH: channel FIFO non-empty.
- `data_out`  out  NUM_CH*DATA_W: channel i occupies bits [i*DATA_W +: DATA_W]; registered.
- `soft_reset`  out  NUM_CH: one-cycle pulse when channel i is flushed.
- `err`  out  1: last packet ended with an error.
- `err_code`  out  4: {flush, addr, length, parity}.

## Operation
- ADDR_W = max(1, clog2(NUM_CH)); LEN_W = DATA_W-ADDR_W. Header is {len[LEN_W-1:0], addr[ADDR_W-1:0]}. A packet is the header, then `len` payload words, then one parity word.
- Parity is the XOR of the header and all payload words. The parity word is written to the FIFO as the last word. The packet length counter is LEN_W+1 bits.
- A word is accepted at a rising edge when `busy`=0 and the FSM is not IDLE without `pkt_valid`.
- FSM states are IDLE, WAIT_EMPTY, LOAD, CHECK and DROP.
  - IDLE: `busy`=0. On `pkt_valid`=1, latch the header and set parity to the header value.
    - If addr >= NUM_CH, go to DROP.
    - Else if FIFO[addr] is empty, write the header and go to LOAD.
    - Else go to WAIT_EMPTY.
  - WAIT_EMPTY: `busy`=1. When FIFO[dest] is empty, write the latched header and go to LOAD.
  - LOAD: `busy` = full[dest], combinational.
    - An accepted word with `pkt_valid`=1 is payload: write it, update parity, increment the count.
    - An accepted word with `pkt_valid`=0 is parity: write it and go to CHECK.
  - CHECK: `busy`=1 for one cycle. Register `err_code[0]` = parity mismatch and `err_code[1]` = (count != len). `err` = OR of the code bits. Return to IDLE.
  - DROP: `busy`=0. Discard words with no FIFO write until the `pkt_valid`=0 word is accepted. Then set `err_code`=4'b0100 and `err`=1, and return to IDLE.
- `err`/`err_code` hold until the next header is accepted, which clears them.
- FIFO behaviour:
  - `vld_out[i]` = ~empty[i].
  - On `read_enb[i]` with non-empty, `data_out[i]` is loaded from the head at that edge.
  - A read when empty is ignored and `data_out` holds.
  - Simultaneous read and write leaves the count unchanged. A write when full cannot occur because `busy` stalls the source.
- Timeout (per channel):
  - The counter increments while `vld_out[i]`=1 and `read_enb[i]`=0. It clears on any read or when the FIFO is empty.
  - On the TIMEOUT-th consecutive such cycle, FIFO i is emptied at that edge and `soft_reset[i]`=1 for the next cycle.
  - If i is the destination in LOAD or WAIT_EMPTY, the FSM goes to DROP, the rest of the packet is discarded, and at the end `err_code`=4'b1000.

## Timing
- Reset values: `busy` 0, `vld_out` 0, `data_out` 0, `soft_reset` 0, `err` 0, `err_code` 0. The FSM is in IDLE, all FIFO pointers and counts are 0, and the timeout counters are 0.
- Reset asserted mid-packet aborts the packet and empties every FIFO in that same edge.
- Header accepted at edge k (FIFO empty): `vld_out[dest]`=1 from cycle k+1.
- `read_enb` high at edge r: the word is on `data_out` after r, i.e. one-cycle read latency.
- Parity accepted at edge p: CHECK in cycle p+1, and `err` is valid after edge p+1. The earliest next header is at edge p+2.
- Peak throughput is 1 word/cycle with no read stall. Overhead is 1 CHECK cycle per packet.

## Test plan
- Header 0x39 (len 14, addr 1), 14 random payload words, correct parity, `read_enb[1]`=1 -> 16 words out in order on channel 1; `err`=0; `busy` high only in the CHECK cycle.
- Header 0x41 (len 16, addr 1), `read_enb[1]`=0 -> `busy`=1 after 16 writes, source held. Raising `read_enb[1]` resumes flow; 18 words delivered, `err`=0.
- Header 0x19 (len 6, addr 1) with parity XOR 0x01 -> all 8 words delivered; `err`=1, `err_code`=4'b0001.
- Header 0x0B (len 2, addr 3, NUM_CH=3) -> no `vld_out` activity; `err_code`=4'b0100; the next packet, to addr 0, routes normally.
- Packet to ch0 (header 0x08) never read -> after 30 cycles of `vld_out[0]` high, `soft_reset[0]` pulses for 1 cycle and `vld_out[0]`=0. A second packet to ch1 while FIFO1 is non-empty -> `busy`=1 in WAIT_EMPTY until FIFO1 drains.
- `reset` asserted for 1 cycle during a LOAD payload word -> all outputs at reset values next cycle; a following clean packet is routed correctly.

Source files
------------

// File: rtl/router_1xn.sv
`default_nettype none
// ============================================================================
// Module   : router_1xn
// Purpose  : 1-to-NUM_CH packet router. A byte stream of header / payload /
//            parity packets is steered into one of NUM_CH output FIFOs by the
//            address field of the header. Invalid addresses are dropped,
//            payload length and parity are checked, and a channel that sits
//            unread for TIMEOUT cycles is flushed.
// Ports    : clock, reset      - rising-edge clock, synchronous active-high reset
//            pkt_valid, data_in - packet word input (pkt_valid low = parity word)
//            read_enb           - per-channel pop request
//            busy               - source must hold its word while high
//            vld_out            - per-channel FIFO non-empty
//            data_out           - per-channel registered read data
//            soft_reset         - one-cycle pulse after a channel is flushed
//            err, err_code      - result of the last packet {flush,addr,len,parity}
// Revision : 1.0 - initial release
// ============================================================================
module router_1xn #(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pkt_valid,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [NUM_CH-1:0]        read_enb,
  output logic                     busy,
  output logic [NUM_CH-1:0]        vld_out,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        soft_reset,
  output logic                     err,
  output logic [3:0]               err_code
);

  localparam int ADDR_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int LEN_W  = DATA_W - ADDR_W;
  localparam int SLOTS  = 1 << ADDR_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W:0] NUM_CH_A = (ADDR_W + 1)'(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_EMPTY = 3'd1,
    S_LOAD       = 3'd2,
    S_CHECK      = 3'd3,
    S_DROP       = 3'd4
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   dest;
  logic [DATA_W-1:0]   hdr;
  logic [DATA_W-1:0]   parity;
  logic [LEN_W:0]      cnt;
  logic                par_bad;
  logic                drop_flush;

  logic [NUM_CH-1:0]   empty;
  logic [NUM_CH-1:0]   full;
  logic [NUM_CH-1:0]   flush;
  // Status vectors widened to every encodable address so that indexing with
  // an out-of-range header address is always well defined.
  logic [SLOTS-1:0]    empty_s;
  logic [SLOTS-1:0]    full_s;
  logic [SLOTS-1:0]    flush_s;

  logic [ADDR_W-1:0]   in_addr;
  logic                in_ok;
  logic [LEN_W-1:0]    hdr_len;
  logic                accept;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_ch;
  logic [DATA_W-1:0]   wr_word;

  assign in_addr = data_in[ADDR_W-1:0];
  assign in_ok   = ({1'b0, in_addr} < NUM_CH_A);
  assign hdr_len = hdr[DATA_W-1:ADDR_W];

  always_comb begin
    empty_s = '1;
    full_s  = '0;
    flush_s = '0;
    empty_s[NUM_CH-1:0] = empty;
    full_s[NUM_CH-1:0]  = full;
    flush_s[NUM_CH-1:0] = flush;
  end

  always_comb begin
    busy = 1'b0;
    case (state)
      S_WAIT_EMPTY, S_CHECK: busy = 1'b1;
      S_LOAD:                busy = full_s[dest];
      default:               busy = 1'b0;
    endcase
  end

  // In IDLE only a word carrying pkt_valid (a header) is taken.
  assign accept = !busy && !((state == S_IDLE) && !pkt_valid);

  always_comb begin
    wr_en   = 1'b0;
    wr_ch   = dest;
    wr_word = data_in;
    case (state)
      S_IDLE: begin
        wr_ch = in_addr;
        wr_en = pkt_valid && in_ok && empty_s[in_addr];
      end
      S_WAIT_EMPTY: begin
        wr_word = hdr;
        wr_en   = empty_s[dest];
      end
      S_LOAD:  wr_en = accept;
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      dest       <= '0;
      hdr        <= '0;
      parity     <= '0;
      cnt        <= '0;
      par_bad    <= 1'b0;
      drop_flush <= 1'b0;
      err        <= 1'b0;
      err_code   <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (pkt_valid) begin
            hdr        <= data_in;
            parity     <= data_in;
            cnt        <= '0;
            dest       <= in_addr;
            drop_flush <= 1'b0;
            err        <= 1'b0;
            err_code   <= 4'b0000;
            if (!in_ok)                  state <= S_DROP;
            else if (empty_s[in_addr])   state <= S_LOAD;
            else                         state <= S_WAIT_EMPTY;
          end
        end
        S_WAIT_EMPTY: begin
          if (flush_s[dest]) begin
            drop_flush <= 1'b1;
            state      <= S_DROP;
          end else if (empty_s[dest]) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (flush_s[dest]) begin
            // Destination flushed under us: if this edge also carries the
            // parity word the packet is already over, otherwise discard the rest.
            if (accept && !pkt_valid) begin
              err      <= 1'b1;
              err_code <= 4'b1000;
              state    <= S_IDLE;
            end else begin
              drop_flush <= 1'b1;
              state      <= S_DROP;
            end
          end else if (accept) begin
            if (pkt_valid) begin
              parity <= parity ^ data_in;
              cnt    <= cnt + 1'b1;
            end else begin
              par_bad <= (data_in != parity);
              state   <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          err_code <= {2'b00, (cnt != {1'b0, hdr_len}), par_bad};
          err      <= (cnt != {1'b0, hdr_len}) || par_bad;
          state    <= S_IDLE;
        end
        S_DROP: begin
          if (!pkt_valid) begin
            err      <= 1'b1;
            err_code <= drop_flush ? 4'b1000 : 4'b0100;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W:0]    count;
    logic [TO_W-1:0]   tcnt;
    logic [DATA_W-1:0] dout;
    logic              sreset;
    logic              wr;
    logic              rd;

    assign wr       = wr_en && (wr_ch == ADDR_W'(i)) && !flush[i];
    assign rd       = read_enb[i] && !empty[i];
    assign empty[i] = (count == '0);
    assign full[i]  = (count == (PTR_W + 1)'(FIFO_DEPTH));
    // Flush fires on the TIMEOUT-th consecutive unread cycle with data present.
    assign flush[i] = !empty[i] && !read_enb[i] && (tcnt == TO_W'(TIMEOUT - 1));

    assign vld_out[i]                    = !empty[i];
    assign data_out[i*DATA_W +: DATA_W]  = dout;
    assign soft_reset[i]                 = sreset;

    always_ff @(posedge clock) begin
      if (wr) mem[wptr] <= wr_word;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        wptr   <= '0;
        rptr   <= '0;
        count  <= '0;
        tcnt   <= '0;
        dout   <= '0;
        sreset <= 1'b0;
      end else begin
        sreset <= flush[i];
        if (flush[i]) begin
          wptr  <= '0;
          rptr  <= '0;
          count <= '0;
          tcnt  <= '0;
        end else begin
          if (wr) wptr <= wptr + 1'b1;
          if (rd) begin
            dout <= mem[rptr];
            rptr <= rptr + 1'b1;
          end
          case ({wr, rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
          endcase
          if (empty[i] || read_enb[i]) tcnt <= '0;
          else                         tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
